instruction_decode: RTL and testbench
=====================================

# instruction_decode

Decode stage of the five-stage MIPS pipeline: the consumer of `InstrD`/`PCPlus4D` from `IF` and the producer of `PCSrcD`/`PCBranchD` back into it. Holds the 32x32 register file, decodes the supported subset, resolves branches and jumps in ID, and registers operands and control into the ID/EX pipeline register. Program counters are word addresses (PC+1 per instruction), matching `IF`.

## Interface
- Parameters: none; the data width is fixed at 32 and the register file is fixed at 32 entries.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `InstrD` input 32: instruction from the IF/ID register.
- `PCPlus4D` input 32: word address of the next sequential instruction.
- `ForwardAD`, `ForwardBD` input 1 each: select `ALUOutM` in place of the rs or rt read data for the branch compare.
- `ALUOutM` input 32: MEM-stage ALU result used by branch forwarding.
- `FlushE` input 1: when high, the ID/EX register loads a bubble.
- `RegWriteW` input 1: write-back enable.
- `WriteRegW` input 5: write-back register index.
- `ResultW` input 32: write-back data.
- `PCSrcD` output 1: combinational redirect request; high for a taken `beq` or for `j`.
- `PCBranchD` output 32: combinational redirect target.
- `RsD`, `RtD` output 5 each: combinational source indices, used by the hazard unit.
- `BranchD` output 1: combinational; high when the decoded instruction is `beq`.
- `RegWriteE`, `MemtoRegE`, `MemWriteE`, `ALUSrcE`, `RegDstE` output 1 each: registered control.
- `ALUControlE` output 3: registered ALU operation.
- `RD1E`, `RD2E`, `SignImmE` output 32 each: registered operands and sign-extended immediate.
- `RsE`, `RtE`, `RdE` output 5 each: registered register indices.

## Operation
- Opcode decode:
  - `000000` R-type: RegWrite=1, RegDst=1.
  - `100011` lw: RegWrite=1, ALUSrc=1, MemtoReg=1, ALU add.
  - `101011` sw: MemWrite=1, ALUSrc=1, ALU add.
  - `001000` addi: RegWrite=1, ALUSrc=1, ALU add.
  - `000100` beq: Branch=1, ALU sub.
  - `000010` j: Jump=1.
- R-type funct to ALUControl:
  - `100000` add → 010.
  - `100010` sub → 110.
  - `100100` and → 000.
  - `100101` or → 001.
  - `101010` slt → 111.
- An unknown opcode or funct decodes as a NOP: all control 0, ALUControl 010, no redirect.
- Register file:
  - Read is combinational on rs=`InstrD[25:21]` and rt=`InstrD[20:16]`.
  - Write on the rising edge when `RegWriteW`=1 and `WriteRegW`≠0.
  - Register 0 always reads 0.
  - Write-through: a read of the index being written in the same cycle returns `ResultW`.
- Branch compare:
  - Operand A = `ForwardAD` ? `ALUOutM` : rs data; operand B = `ForwardBD` ? `ALUOutM` : rt data.
  - EqualD = (A == B).
- `PCSrcD` = (Branch & EqualD) | Jump.
- `PCBranchD`:
  - For `j`: {`PCPlus4D[31:26]`, `InstrD[25:0]`}.
  - Otherwise: `PCPlus4D` + SignImm.
  - SignImm = {16{`InstrD[15]`}, `InstrD[15:0]`}; the addition is 32-bit and wraps modulo 2^32.
- ID/EX register:
  - Every cycle it loads the decoded control, RD1/RD2 (unforwarded, after write-through), SignImm, and rs/rt/rd=`InstrD[15:11]`.
  - It has no stall input; a stall in ID is turned into a bubble by the hazard unit asserting `FlushE`.

## Timing
- `reset` (synchronous):
  - All ID/EX outputs and all 32 registers go to 0 on the edge where `reset`=1.
  - `reset` dominates `FlushE` and `RegWriteW`.
  - Asserting it mid-stream discards the in-flight instruction.
- `FlushE`=1 at an edge: all ID/EX control and data outputs become 0 (bubble) that cycle.
- Latency:
  - Decode, compare and redirect outputs are zero-cycle combinational from `InstrD`.
  - ID/EX outputs appear one cycle after `InstrD` is presented.
- Write-back:
  - A write at edge N is visible on the combinational reads in the same cycle via write-through.
  - It is visible in `RD1E`/`RD2E` at edge N.
- `InstrD`=0 (IF flush value) decodes as sll $0, a harmless NOP: funct `000000` gives the NOP decode.

## Configuration
- `ID_JUMP_EN` defined: `j` is decoded as above.
- `ID_JUMP_EN` undefined:
  - Opcode `000010` decodes as a NOP and Jump is tied to 0.
  - `PCBranchD` is always `PCPlus4D` + SignImm.

## Test plan
- Reset:
  - Stimulus: hold `reset` for 2 cycles, then present `InstrD`=0x00221820 (add $3,$1,$2).
  - Response: `RD1E`=`RD2E`=0, RegWriteE=1, ALUControlE=010, RdE=3.
- Write-through:
  - Stimulus: `RegWriteW`=1, `WriteRegW`=1, `ResultW`=0x1234 in the same cycle as `InstrD`=0x00221820.
  - Response: `RD1E`=0x1234 next cycle.
  - Stimulus: a write to $0.
  - Response: $0 still reads 0.
- Branch taken:
  - Stimulus: $1=$2=5, `InstrD`=0x1022FFFE (beq $1,$2,-2), `PCPlus4D`=0x10.
  - Response: `PCSrcD`=1, `PCBranchD`=0x0E.
  - Stimulus: set $2=6.
  - Response: `PCSrcD`=0.
- Forwarding:
  - Stimulus: $1=0, $2=7, `ForwardAD`=1, `ALUOutM`=7, beq $1,$2.
  - Response: `PCSrcD`=1.
- Flush and reset dominance:
  - Stimulus: `FlushE`=1 with lw decoded.
  - Response: RegWriteE=MemtoRegE=0 next cycle.
  - Stimulus: `reset` and `RegWriteW` together.
  - Response: register is not written.
- Jump:
  - Stimulus: `InstrD`=0x08000020, `PCPlus4D`=0x04000005.
  - Response with `ID_JUMP_EN`: `PCSrcD`=1, `PCBranchD`=0x04000020.
  - Response without `ID_JUMP_EN`: `PCSrcD`=0, RegWriteE=0.

Source files
------------

// File: rtl/instruction_decode.sv
// instruction_decode: ID stage of the five-stage MIPS pipeline.
// Decodes the supported subset, holds the 32x32 register file with
// write-through, resolves beq/j in ID and registers the ID/EX stage.
// Optional feature: define ID_JUMP_EN to decode the j instruction.
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCPlus4D,
  input  logic        ForwardAD,
  input  logic        ForwardBD,
  input  logic [31:0] ALUOutM,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] ResultW,
  output logic        PCSrcD,
  output logic [31:0] PCBranchD,
  output logic [4:0]  RsD,
  output logic [4:0]  RtD,
  output logic        BranchD,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        RegDstE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] SignImmE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rd_idx;
  logic [31:0] sign_imm;
  logic        reg_write;
  logic        mem_to_reg;
  logic        mem_write;
  logic        alu_src;
  logic        reg_dst;
  logic        branch;
  logic        jump;
  logic [2:0]  alu_control;
  logic [31:0] regs [32];
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic        equal_d;
  logic        unused_shamt;

  assign opcode       = InstrD[31:26];
  assign funct        = InstrD[5:0];
  assign RsD          = InstrD[25:21];
  assign RtD          = InstrD[20:16];
  assign rd_idx       = InstrD[15:11];
  assign sign_imm     = {{16{InstrD[15]}}, InstrD[15:0]};
  assign unused_shamt = ^InstrD[10:6];

  // Main and ALU decode; anything unrecognised falls out as a NOP
  always_comb begin
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    alu_src     = 1'b0;
    reg_dst     = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    alu_control = 3'b010;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b010; end
          6'b100010: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b110; end
          6'b100100: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b000; end
          6'b100101: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b001; end
          6'b101010: begin reg_write = 1'b1; reg_dst = 1'b1; alu_control = 3'b111; end
          default: ;
        endcase
      end
      6'b100011: begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; end
      6'b101011: begin mem_write = 1'b1; alu_src = 1'b1; end
      6'b001000: begin reg_write = 1'b1; alu_src = 1'b1; end
      6'b000100: begin branch = 1'b1; alu_control = 3'b110; end
`ifdef ID_JUMP_EN
      6'b000010: jump = 1'b1;
`endif
      default: ;
    endcase
  end

  // Register file reads with write-through from the write-back stage; $0 is hardwired to 0
  always_comb begin
    rd1 = regs[RsD];
    rd2 = regs[RtD];
    if (RsD == 5'd0)
      rd1 = 32'd0;
    else if (RegWriteW && (WriteRegW == RsD))
      rd1 = ResultW;
    if (RtD == 5'd0)
      rd2 = 32'd0;
    else if (RegWriteW && (WriteRegW == RtD))
      rd2 = ResultW;
  end

  // Register file write port; reset clears every entry and blocks the write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= 32'd0;
    end else if (RegWriteW && (WriteRegW != 5'd0)) begin
      regs[WriteRegW] <= ResultW;
    end
  end

  assign cmp_a   = ForwardAD ? ALUOutM : rd1;
  assign cmp_b   = ForwardBD ? ALUOutM : rd2;
  assign equal_d = (cmp_a == cmp_b);
  assign BranchD = branch;
  assign PCSrcD  = (branch & equal_d) | jump;

  // Redirect target: pseudo-direct for j, otherwise PC-relative
  always_comb begin
    PCBranchD = PCPlus4D + sign_imm;
    if (jump)
      PCBranchD = {PCPlus4D[31:26], InstrD[25:0]};
  end

  // ID/EX pipeline register; reset and flush both load a bubble
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      RegWriteE   <= 1'b0;
      MemtoRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      RegDstE     <= 1'b0;
      ALUControlE <= 3'b000;
      RD1E        <= 32'd0;
      RD2E        <= 32'd0;
      SignImmE    <= 32'd0;
      RsE         <= 5'd0;
      RtE         <= 5'd0;
      RdE         <= 5'd0;
    end else begin
      RegWriteE   <= reg_write;
      MemtoRegE   <= mem_to_reg;
      MemWriteE   <= mem_write;
      ALUSrcE     <= alu_src;
      RegDstE     <= reg_dst;
      ALUControlE <= alu_control;
      RD1E        <= rd1;
      RD2E        <= rd2;
      SignImmE    <= sign_imm;
      RsE         <= RsD;
      RtE         <= RtD;
      RdE         <= rd_idx;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed vectors with hand-computed expectations
// for the ID stage, covering reset, write-through, branch, forwarding,
// flush, reset dominance and the ID_JUMP_EN-dependent j decode.
module tb_instruction_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ForwardAD;
  logic        ForwardBD;
  logic [31:0] ALUOutM;
  logic        FlushE;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic        BranchD;
  logic        RegWriteE;
  logic        MemtoRegE;
  logic        MemWriteE;
  logic        ALUSrcE;
  logic        RegDstE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] SignImmE;
  logic [4:0]  RsE;
  logic [4:0]  RtE;
  logic [4:0]  RdE;

  int testCount = 0;
  int failCount = 0;

  instruction_decode dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ALUOutM(ALUOutM),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
    .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .RegWriteE(RegWriteE),
    .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE), .ALUSrcE(ALUSrcE),
    .RegDstE(RegDstE), .ALUControlE(ALUControlE), .RD1E(RD1E),
    .RD2E(RD2E), .SignImmE(SignImmE), .RsE(RsE), .RtE(RtE), .RdE(RdE)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
    InstrD   = instr;
    PCPlus4D = pc;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] value);
    RegWriteW = 1'b1;
    WriteRegW = idx;
    ResultW   = value;
    stepClock();
    RegWriteW = 1'b0;
  endtask

  initial begin
    reset = 1'b1; InstrD = 32'd0; PCPlus4D = 32'd0; ForwardAD = 1'b0; ForwardBD = 1'b0;
    ALUOutM = 32'd0; FlushE = 1'b0; RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'd0;

    // reset held for two cycles, then add $3,$1,$2
    stepClock();
    stepClock();
    checkOutput("reset_regwrite", {31'd0, RegWriteE}, 32'd0);
    checkOutput("reset_aluctl", {29'd0, ALUControlE}, 32'd0);
    reset = 1'b0;
    applyStimulus(32'h00221820, 32'd1);
    checkOutput("add_rsd", {27'd0, RsD}, 32'd1);
    checkOutput("add_rtd", {27'd0, RtD}, 32'd2);
    stepClock();
    checkOutput("add_rd1e", RD1E, 32'd0);
    checkOutput("add_rd2e", RD2E, 32'd0);
    checkOutput("add_regwrite", {31'd0, RegWriteE}, 32'd1);
    checkOutput("add_regdst", {31'd0, RegDstE}, 32'd1);
    checkOutput("add_aluctl", {29'd0, ALUControlE}, 32'h2);
    checkOutput("add_rde", {27'd0, RdE}, 32'd3);
    checkOutput("add_rse", {27'd0, RsE}, 32'd1);

    // write-through of $1 in the same cycle as the read
    writeReg(5'd1, 32'h1234);
    checkOutput("wt_rd1e", RD1E, 32'h1234);
    stepClock();
    checkOutput("stored_rd1e", RD1E, 32'h1234);

    // write to $0 never lands or bypasses
    applyStimulus(32'h00001820, 32'd1);
    writeReg(5'd0, 32'hDEAD);
    checkOutput("r0_wt", RD1E, 32'd0);
    stepClock();
    checkOutput("r0_stored", RD2E, 32'd0);

    // beq $1,$2,-2 with equal operands
    writeReg(5'd1, 32'd5);
    writeReg(5'd2, 32'd5);
    applyStimulus(32'h1022FFFE, 32'h10);
    checkOutput("beq_branchd", {31'd0, BranchD}, 32'd1);
    checkOutput("beq_taken", {31'd0, PCSrcD}, 32'd1);
    checkOutput("beq_target", PCBranchD, 32'h0000000E);
    stepClock();
    checkOutput("beq_aluctl", {29'd0, ALUControlE}, 32'h6);
    checkOutput("beq_regwrite", {31'd0, RegWriteE}, 32'd0);
    checkOutput("beq_signimm", SignImmE, 32'hFFFFFFFE);

    // $2 becomes 6: visible combinationally while the write is pending
    RegWriteW = 1'b1; WriteRegW = 5'd2; ResultW = 32'd6;
    #1;
    checkOutput("beq_nt_wt", {31'd0, PCSrcD}, 32'd0);
    stepClock();
    RegWriteW = 1'b0;
    #1;
    checkOutput("beq_nt", {31'd0, PCSrcD}, 32'd0);

    // forwarding into the branch compare
    writeReg(5'd1, 32'd0);
    writeReg(5'd2, 32'd7);
    ForwardAD = 1'b1; ALUOutM = 32'd7;
    #1;
    checkOutput("fwd_a_taken", {31'd0, PCSrcD}, 32'd1);
    ForwardAD = 1'b0;
    #1;
    checkOutput("fwd_a_off", {31'd0, PCSrcD}, 32'd0);
    ForwardBD = 1'b1; ALUOutM = 32'd0;
    #1;
    checkOutput("fwd_b_taken", {31'd0, PCSrcD}, 32'd1);
    ForwardBD = 1'b0;

    // lw $5,8($1), then the same lw flushed
    applyStimulus(32'h8C250008, 32'h20);
    checkOutput("lw_pcsrc", {31'd0, PCSrcD}, 32'd0);
    stepClock();
    checkOutput("lw_regwrite", {31'd0, RegWriteE}, 32'd1);
    checkOutput("lw_memtoreg", {31'd0, MemtoRegE}, 32'd1);
    checkOutput("lw_alusrc", {31'd0, ALUSrcE}, 32'd1);
    checkOutput("lw_signimm", SignImmE, 32'd8);
    checkOutput("lw_rte", {27'd0, RtE}, 32'd5);
    FlushE = 1'b1;
    stepClock();
    FlushE = 1'b0;
    checkOutput("flush_regwrite", {31'd0, RegWriteE}, 32'd0);
    checkOutput("flush_memtoreg", {31'd0, MemtoRegE}, 32'd0);
    checkOutput("flush_signimm", SignImmE, 32'd0);
    checkOutput("flush_rte", {27'd0, RtE}, 32'd0);

    // sw, addi, remaining R-type functs, unknown funct/opcode, sll $0
    applyStimulus(32'hAC250008, 32'h20);
    stepClock();
    checkOutput("sw_memwrite", {31'd0, MemWriteE}, 32'd1);
    checkOutput("sw_regwrite", {31'd0, RegWriteE}, 32'd0);
    applyStimulus(32'h2025FFFF, 32'h20);
    stepClock();
    checkOutput("addi_regwrite", {31'd0, RegWriteE}, 32'd1);
    checkOutput("addi_alusrc", {31'd0, ALUSrcE}, 32'd1);
    checkOutput("addi_memtoreg", {31'd0, MemtoRegE}, 32'd0);
    applyStimulus(32'h00221822, 32'h20);
    stepClock();
    checkOutput("sub_aluctl", {29'd0, ALUControlE}, 32'h6);
    applyStimulus(32'h00221824, 32'h20);
    stepClock();
    checkOutput("and_aluctl", {29'd0, ALUControlE}, 32'h0);
    applyStimulus(32'h00221825, 32'h20);
    stepClock();
    checkOutput("or_aluctl", {29'd0, ALUControlE}, 32'h1);
    applyStimulus(32'h0022182A, 32'h20);
    stepClock();
    checkOutput("slt_aluctl", {29'd0, ALUControlE}, 32'h7);
    checkOutput("slt_regwrite", {31'd0, RegWriteE}, 32'd1);
    applyStimulus(32'h00221821, 32'h20);
    stepClock();
    checkOutput("badfunct_regwrite", {31'd0, RegWriteE}, 32'd0);
    checkOutput("badfunct_aluctl", {29'd0, ALUControlE}, 32'h2);
    applyStimulus(32'hFC000000, 32'h20);
    checkOutput("badop_pcsrc", {31'd0, PCSrcD}, 32'd0);
    stepClock();
    checkOutput("badop_regwrite", {31'd0, RegWriteE}, 32'd0);
    applyStimulus(32'h00000000, 32'h20);
    stepClock();
    checkOutput("nop_regwrite", {31'd0, RegWriteE}, 32'd0);
    checkOutput("nop_regdst", {31'd0, RegDstE}, 32'd0);

    // reset with lw in flight and a pending write-back of $4
    applyStimulus(32'h8C250008, 32'h20);
    reset = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'h99;
    stepClock();
    reset = 1'b0; RegWriteW = 1'b0;
    checkOutput("rst_discard", {31'd0, RegWriteE}, 32'd0);
    applyStimulus(32'h00821820, 32'h20);
    stepClock();
    checkOutput("rst_blocks_write", RD1E, 32'd0);
    checkOutput("rst_clears_r2", RD2E, 32'd0);

    // j 0x20 from PC 0x04000005
    applyStimulus(32'h08000020, 32'h04000005);
`ifdef ID_JUMP_EN
    checkOutput("j_pcsrc", {31'd0, PCSrcD}, 32'd1);
    checkOutput("j_target", PCBranchD, 32'h04000020);
`else
    checkOutput("j_pcsrc", {31'd0, PCSrcD}, 32'd0);
    checkOutput("j_target", PCBranchD, 32'h04000025);
`endif
    stepClock();
    checkOutput("j_regwrite", {31'd0, RegWriteE}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
